// File: rtl/ram_responder_if.sv
// rtl/ram_responder_if.sv - request/acknowledge bus between the CPU memory controller and ram_responder
interface ram_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              req;
    logic              ram_rw_flag;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              ack;
    logic              busy;
    logic              err_oor;

    modport master (
        output req, ram_rw_flag, address, wr_data,
        input  rd_data, ack, busy, err_oor
    );

    modport slave (
        input  req, ram_rw_flag, address, wr_data,
        output rd_data, ack, busy, err_oor
    );
endinterface

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - word-addressed data RAM with registered reads and configurable wait states
// Optional out-of-range checking is enabled by defining RAM_OOR_CHECK_EN.
module ram_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    ram_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              ack_q;
    logic              busy_q;
    logic              err_q;
    logic              accept;
    logic              oor;
    logic              wr_en;
    logic [IDX_W-1:0]  idx;

    // A request still held high during the ack cycle must not start a second access.
    assign accept = (state == IDLE) && bus.req && !ack_q;
    assign idx    = lat_addr[IDX_W-1:0];

`ifdef RAM_OOR_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    assign oor = ({1'b0, lat_addr} >= DEPTH_X);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^lat_addr;
    assign oor              = 1'b0;
`endif

    assign wr_en = (state == ACCESS) && lat_rw && !oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ACCESS;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = ACCESS;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_rw    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rd_q      <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (accept) begin
                lat_rw    <= bus.ram_rw_flag;
                lat_addr  <= bus.address;
                lat_wdata <= bus.wr_data;
                busy_q    <= 1'b1;
            end
            if (state == ACCESS) begin
                ack_q  <= 1'b1;
                busy_q <= 1'b0;
                err_q  <= oor;
                if (!lat_rw) begin
                    rd_q <= oor ? '0 : mem[idx];
                end
            end
        end
    end

    // No reset on the array: contents survive reset, and a write is lost if reset hits before ACCESS.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= lat_wdata;
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.ack     = ack_q;
    assign bus.busy    = busy_q;
    assign bus.err_oor = err_q;
endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - self-checking bench for ram_responder with zero and three wait states
module tb_ram_responder;
    localparam int DW = 32;
    localparam int AW = 16;
`ifdef RAM_OOR_CHECK_EN
    localparam bit OOR = 1'b1;
`else
    localparam bit OOR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          req_v [2];
    logic          rw_v  [2];
    logic [AW-1:0] addr_v[2];
    logic [DW-1:0] wd_v  [2];
    logic          ack_v [2];
    logic          busy_v[2];
    logic          err_v [2];
    logic [DW-1:0] rd_v  [2];

    ram_responder_if #(.DATA_W(DW), .ADDR_W(AW)) b0();
    ram_responder_if #(.DATA_W(DW), .ADDR_W(AW)) b1();

    assign b0.req = req_v[0];  assign b0.ram_rw_flag = rw_v[0];
    assign b0.address = addr_v[0];  assign b0.wr_data = wd_v[0];
    assign b1.req = req_v[1];  assign b1.ram_rw_flag = rw_v[1];
    assign b1.address = addr_v[1];  assign b1.wr_data = wd_v[1];
    assign ack_v[0] = b0.ack;  assign busy_v[0] = b0.busy;
    assign err_v[0] = b0.err_oor;  assign rd_v[0] = b0.rd_data;
    assign ack_v[1] = b1.ack;  assign busy_v[1] = b1.busy;
    assign err_v[1] = b1.err_oor;  assign rd_v[1] = b1.rd_data;

    ram_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));
    ram_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));

    typedef struct { logic [DW-1:0] rd; logic err; } exp_t;
    typedef struct {
        int inst; logic rw; logic [AW-1:0] a; logic [DW-1:0] wd; logic [DW-1:0] rd; logic err;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    vec_t tbl[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic [DW-1:0] rd, input logic err);
        exp_t e;
        e.rd = rd;
        e.err = err;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Scoreboard: every ack pops one expectation for that instance.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (ack_v[i]) begin
                    exp_t e;
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_ack: inst %0d got ack with empty scoreboard", i);
                    end else begin
                        if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
                        check($sformatf("rd_data[%0d]", i), 64'(rd_v[i]), 64'(e.rd));
                        check($sformatf("err_oor[%0d]", i), 64'(err_v[i]), 64'(e.err));
                    end
                end
            end
        end
    end

    task automatic txn(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] exp_rd, input logic exp_err);
        int k;
        int nb;
        bit seen;
        @(negedge clk);
        req_v[i] = 1'b1; rw_v[i] = rw; addr_v[i] = a; wd_v[i] = wd;
        push(i, exp_rd, exp_err);
        k = 0; nb = 0; seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                rw_v[i] = ~rw; addr_v[i] = ~a; wd_v[i] = ~wd;
            end
            if (ack_v[i]) seen = 1'b1;
            else if (busy_v[i]) nb++;
        end
        req_v[i] = 1'b0;
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: inst %0d addr %0h no ack within 40 cycles", i, a);
            if (i == 0) q0.delete(); else q1.delete();
        end else begin
            check($sformatf("latency[%0d]", i), 64'(k), (i == 0) ? 64'd2 : 64'd5);
            check($sformatf("busy_cycles[%0d]", i), 64'(nb), (i == 0) ? 64'd1 : 64'd4);
            @(negedge clk);
            check($sformatf("ack_width[%0d]", i), 64'(ack_v[i]), 64'd0);
        end
    endtask

    task automatic check_reset_outputs(input int i);
        check($sformatf("rst_rd_data[%0d]", i), 64'(rd_v[i]), 64'd0);
        check($sformatf("rst_ack[%0d]", i), 64'(ack_v[i]), 64'd0);
        check($sformatf("rst_busy[%0d]", i), 64'(busy_v[i]), 64'd0);
        check($sformatf("rst_err_oor[%0d]", i), 64'(err_v[i]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, t1, t2;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; rw_v[i] = 1'b0; addr_v[i] = '0; wd_v[i] = '0;
        end
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back('{0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0});
        tbl.push_back('{0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1, 1'b1, 16'h0003, 32'h0000A5A5, 32'h0, 1'b0});
        tbl.push_back('{1, 1'b1, 16'h0020, 32'h22222222, 32'h0, 1'b0});
        tbl.push_back('{1, 1'b0, 16'h0003, 32'h0, 32'h0000A5A5, 1'b0});
        tbl.push_back('{0, 1'b1, 16'h0005, 32'h0BADF00D, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{0, 1'b1, 16'h0105, 32'h12345678, 32'hDEADBEEF, OOR});
        tbl.push_back('{0, 1'b0, 16'h0005, 32'h0, OOR ? 32'h0BADF00D : 32'h12345678, 1'b0});
        tbl.push_back('{0, 1'b0, 16'h0105, 32'h0, OOR ? 32'h0 : 32'h12345678, OOR});
        tbl.push_back('{0, 1'b1, 16'h00FF, 32'hCAFEF00D, OOR ? 32'h0 : 32'h12345678, 1'b0});
        tbl.push_back('{0, 1'b0, 16'h00FF, 32'h0, 32'hCAFEF00D, 1'b0});
        tbl.push_back('{1, 1'b0, 16'h0020, 32'h0, 32'h22222222, 1'b0});
        foreach (tbl[j])
            txn(tbl[j].inst, tbl[j].rw, tbl[j].a, tbl[j].wd, tbl[j].rd, tbl[j].err);

        // Request held high across two reads on the three-wait-state instance.
        @(negedge clk);
        req_v[1] = 1'b1; rw_v[1] = 1'b0; addr_v[1] = 16'h0003;
        push(1, 32'h0000A5A5, 1'b0);
        push(1, 32'h0000A5A5, 1'b0);
        acks = 0; t1 = -1; t2 = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack_v[1]) begin
                acks++;
                if (acks == 1) t1 = k;
                else if (acks == 2) begin t2 = k; req_v[1] = 1'b0; end
            end
        end
        req_v[1] = 1'b0;
        check("held_ack_count", 64'(acks), 64'd2);
        check("held_first_ack", 64'(t1), 64'd5);
        check("held_ack_spacing", 64'(t2 - t1), 64'd6);
        q1.delete();

        // Reset while a write is parked in WAIT must leave the old word intact.
        @(negedge clk);
        req_v[1] = 1'b1; rw_v[1] = 1'b1; addr_v[1] = 16'h0020; wd_v[1] = 32'h11111111;
        @(negedge clk);
        check("busy_in_wait", 64'(busy_v[1]), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        req_v[1] = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txn(1, 1'b0, 16'h0020, 32'h0, 32'h22222222, 1'b0);
        txn(0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
